// File: rtl/ethernet_pkg.sv
// Shared Ethernet block types: RX DMA state encoding, stream word layout and
// the controller register map used by the RX DMA and the control unit.
package ethernet_pkg;

  localparam int eth_data_width_lp = 32;
  localparam int eth_addr_width_lp = 14;
  localparam int eth_mtu_lp        = 2048;

  localparam logic [eth_addr_width_lp-1:0] eth_rx_buf_base_lp  = 14'h0000;
  localparam logic [eth_addr_width_lp-1:0] eth_rx_size_addr_lp = 14'h1004;
  localparam logic [eth_addr_width_lp-1:0] eth_rx_ack_addr_lp  = 14'h1010;

  typedef enum logic [2:0] {
    IDLE, RD_SIZE, WAIT_SIZE, DATA, ACK, HOLDOFF
  } rx_dma_state_e;

  typedef struct packed {
    logic [eth_data_width_lp-1:0]   data;
    logic [eth_data_width_lp/8-1:0] keep;
    logic                           last;
  } eth_stream_word_s;

endpackage

// File: rtl/bsg_two_fifo.sv
// Two-entry ready/valid FIFO with registered storage; head is presented
// directly so data stays stable until it is consumed.
module bsg_two_fifo #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] mem_r [2];
  logic               head_r, tail_r;
  logic [1:0]         count_r;
  logic               enq, deq;

  assign ready_o = (count_r != 2'd2);
  assign v_o     = (count_r != 2'd0);
  assign data_o  = mem_r[head_r];
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head_r  <= 1'b0;
      tail_r  <= 1'b0;
      count_r <= 2'd0;
    end else begin
      if (enq) tail_r <= ~tail_r;
      if (deq) head_r <= ~head_r;
      count_r <= count_r + 2'(enq) - 2'(deq);
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_r[tail_r] <= data_i;
  end

endmodule

// File: rtl/ethernet_rx_dma.sv
// Drains received frames from the Ethernet controller register port into an
// AXIS-style stream, then acknowledges each frame so the controller frees it.
module ethernet_rx_dma
  import ethernet_pkg::*;
#(
  parameter int data_width_p = eth_data_width_lp,
  parameter int addr_width_p = eth_addr_width_lp,
  parameter int eth_mtu_p    = eth_mtu_lp,
  parameter logic [addr_width_p-1:0] rx_buf_base_p  = eth_rx_buf_base_lp,
  parameter logic [addr_width_p-1:0] rx_size_addr_p = eth_rx_size_addr_lp,
  parameter logic [addr_width_p-1:0] rx_ack_addr_p  = eth_rx_ack_addr_lp
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      enable_i,
  input  logic                      rx_avail_i,
  output logic [addr_width_p-1:0]   addr_o,
  output logic                      read_en_o,
  output logic                      write_en_o,
  output logic [data_width_p/8-1:0] write_mask_o,
  output logic [data_width_p-1:0]   write_data_o,
  input  logic [data_width_p-1:0]   read_data_i,
  output logic [data_width_p-1:0]   m_tdata_o,
  output logic [data_width_p/8-1:0] m_tkeep_o,
  output logic                      m_tlast_o,
  output logic                      m_tvalid_o,
  input  logic                      m_tready_i,
  output logic                      busy_o,
  output logic                      error_o,
  output logic [15:0]               frame_count_o
);

  localparam int bytes_lp      = data_width_p/8;
  localparam int lg_bytes_lp   = $clog2(bytes_lp);
  localparam int size_width_lp = $clog2(eth_mtu_p+1);
  localparam int fifo_width_lp = data_width_p + bytes_lp + 1;

  typedef struct packed {
    logic [data_width_p-1:0] data;
    logic [bytes_lp-1:0]     keep;
    logic                    last;
  } rx_word_s;

  rx_dma_state_e            state_r;
  logic [size_width_lp-1:0] words_r, rd_idx_r, rsp_idx_r;
  logic [lg_bytes_lp-1:0]   rem_r;
  logic [1:0]               occ_r;
  logic                     pend_r, err_r, error_r, hold_r;
  logic [15:0]              count_r;

  rx_word_s                 enq_word, deq_word;
  logic                     fifo_ready, fifo_v, deq;
  logic [1:0]               committed;
  logic                     issue;
  logic [size_width_lp-1:0] size_in, words_in;
  logic                     size_bad;
  logic [bytes_lp-1:0]      tail_keep;

  assign size_in  = read_data_i[size_width_lp-1:0];
  assign size_bad = (size_in == '0) || (size_in > size_width_lp'(eth_mtu_p));
  assign words_in = (size_in + size_width_lp'(bytes_lp-1)) >> lg_bytes_lp;

  // Credits count what will sit in the FIFO after this cycle: the word
  // returning now plus current occupancy, less any word leaving now.
  assign deq       = fifo_v & m_tready_i;
  assign committed = occ_r + 2'(pend_r) - 2'(deq);
  assign issue     = (state_r == DATA) && (rd_idx_r != words_r) &&
                     (committed < 2'd2) && fifo_ready;

  assign tail_keep = (rem_r == '0) ? '1 : bytes_lp'((1 << rem_r) - 1);

  always_comb begin
    enq_word      = '0;
    enq_word.data = read_data_i;
    enq_word.last = (rsp_idx_r == words_r - size_width_lp'(1));
    enq_word.keep = enq_word.last ? tail_keep : '1;
  end

  bsg_two_fifo #(.width_p(fifo_width_lp)) out_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .ready_o (fifo_ready),
    .data_i  (enq_word),
    .v_i     (pend_r),
    .v_o     (fifo_v),
    .data_o  (deq_word),
    .yumi_i  (deq)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r   <= IDLE;
      words_r   <= '0;
      rd_idx_r  <= '0;
      rsp_idx_r <= '0;
      rem_r     <= '0;
      occ_r     <= 2'd0;
      pend_r    <= 1'b0;
      err_r     <= 1'b0;
      error_r   <= 1'b0;
      hold_r    <= 1'b0;
      count_r   <= 16'd0;
    end else begin
      error_r <= 1'b0;
      pend_r  <= issue;
      occ_r   <= committed;
      if (issue)  rd_idx_r  <= rd_idx_r + size_width_lp'(1);
      if (pend_r) rsp_idx_r <= rsp_idx_r + size_width_lp'(1);
      unique case (state_r)
        IDLE:    if (enable_i && rx_avail_i) state_r <= RD_SIZE;
        RD_SIZE: state_r <= WAIT_SIZE;
        WAIT_SIZE: begin
          rem_r     <= size_in[lg_bytes_lp-1:0];
          words_r   <= words_in;
          rd_idx_r  <= '0;
          rsp_idx_r <= '0;
          err_r     <= size_bad;
          error_r   <= size_bad;
          state_r   <= size_bad ? ACK : DATA;
        end
        DATA:    if (deq && deq_word.last) state_r <= ACK;
        ACK: begin
          if (!err_r) count_r <= count_r + 16'd1;
          hold_r  <= 1'b0;
          state_r <= HOLDOFF;
        end
        // rx_avail_i lags the ack write; ignore it until it has dropped
        HOLDOFF: begin
          hold_r <= 1'b1;
          if (hold_r) state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  always_comb begin
    addr_o = '0;
    if (state_r == RD_SIZE)  addr_o = rx_size_addr_p;
    else if (issue)          addr_o = rx_buf_base_p + (addr_width_p'(rd_idx_r) << lg_bytes_lp);
    else if (state_r == ACK) addr_o = rx_ack_addr_p;
  end

  assign read_en_o     = (state_r == RD_SIZE) | issue;
  assign write_en_o    = (state_r == ACK);
  assign write_mask_o  = {bytes_lp{write_en_o}};
  assign write_data_o  = data_width_p'(write_en_o);

  assign m_tvalid_o    = fifo_v;
  assign m_tdata_o     = fifo_v ? deq_word.data : '0;
  assign m_tkeep_o     = fifo_v ? deq_word.keep : '0;
  assign m_tlast_o     = fifo_v & deq_word.last;

  assign busy_o        = (state_r != IDLE);
  assign error_o       = error_r;
  assign frame_count_o = count_r;

endmodule
